// File: rtl/usb_pkg.sv
// Shared types and constants for the USB low/full-speed transmit path.
// Line encodings, FSM states and bit-stuffing limits.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_STUFF,
    ST_EOP_SE0_1,
    ST_EOP_SE0_2,
    ST_EOP_J
  } tx_state_t;

  typedef logic [1:0] line_t;

  // {dp, dm}
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam int STUFF_LIMIT  = 6;
  localparam int EOP_SE0_BITS = 2;
  localparam int CNT_W        = $clog2(STUFF_LIMIT + 1);

  function automatic line_t nrzi_toggle(line_t l);
    return (l == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_stuff_counter.sv
// Consecutive-ones counter for bit stuffing.
// limit flags the increment that reaches STUFF_LIMIT.
module usb_stuff_counter
  import usb_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic inc,
  output logic limit
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign limit = inc && (count_q == CNT_W'(STUFF_LIMIT - 1));

endmodule

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: NRZI, bit stuffing and EOP generation.
// Line register holds the symbol launched by the most recent strobe.
module usb_tx_encoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic shift_en,
  input  logic tx_start,
  input  logic tx_bit,
  input  logic tx_bit_valid,
  input  logic tx_last,
  output logic dp_out,
  output logic dm_out,
  output logic bit_ack,
  output logic busy,
  output logic done,
  output logic error
);

  tx_state_t state_q, state_d;
  line_t     line_q, line_d;
  logic      stuff_last_q;
  logic      consume;
  logic      cnt_clr, cnt_inc, cnt_limit;

  usb_stuff_counter u_stuff_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit)
  );

  assign consume = (state_q == ST_SEND) && shift_en && tx_bit_valid;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      line_q       <= LINE_J;
      stuff_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      // remember whether the bit that forced a stuff was the last one
      if (cnt_limit) begin
        stuff_last_q <= tx_last;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (shift_en) begin
          if (!tx_bit_valid)  state_d = ST_EOP_SE0_1;
          else if (cnt_limit) state_d = ST_STUFF;
          else if (tx_last)   state_d = ST_EOP_SE0_1;
        end
      end
      ST_STUFF: begin
        if (shift_en) begin
          state_d = stuff_last_q ? ST_EOP_SE0_1 : ST_SEND;
        end
      end
      ST_EOP_SE0_1: begin
        if (shift_en) state_d = ST_EOP_SE0_2;
      end
      ST_EOP_SE0_2: begin
        if (shift_en) state_d = ST_EOP_J;
      end
      ST_EOP_J: begin
        if (shift_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_d  = line_q;
    bit_ack = consume;
    error   = (state_q == ST_SEND) && shift_en && !tx_bit_valid;
    done    = (state_q == ST_EOP_J) && shift_en;
    busy    = (state_q != ST_IDLE);
    cnt_inc = consume && tx_bit;
    cnt_clr = ((state_q == ST_IDLE) && tx_start)
            || (consume && !tx_bit)
            || ((state_q == ST_STUFF) && shift_en);
    unique case (1'b1)
      (state_q == ST_IDLE):
        line_d = LINE_J;
      consume && !tx_bit:
        line_d = nrzi_toggle(line_q);
      (state_q == ST_STUFF) && shift_en:
        line_d = nrzi_toggle(line_q);
      (state_q == ST_EOP_SE0_1) && shift_en,
      (state_q == ST_EOP_SE0_2) && shift_en:
        line_d = LINE_SE0;
      (state_q == ST_EOP_J) && shift_en:
        line_d = LINE_J;
      default:
        line_d = line_q;
    endcase
  end

  assign {dp_out, dm_out} = line_q;

endmodule
